adc_stream_packetizer: RTL and testbench

//  Transmit end of the ADC-to-DMA S2MM AXI-Stream link in the digitizer PL.

---
 rtl/adc_stream_packetizer_pkg.sv | 14 +
 rtl/adc_stream_packetizer_if.sv | 15 +
 rtl/adc_stream_packetizer_stream_fifo.sv | 74 +++++++
 rtl/adc_stream_packetizer.sv | 137 +++++++++++++
 tb/tb_adc_stream_packetizer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_stream_packetizer_pkg.sv
// Shared types and constants for the digitizer ADC-to-DMA stream path.
package digitizer_pkg;

   localparam int         SAMPLE_W_DEF  = 16;
   localparam int         KEEP_W        = 4;
   localparam logic [3:0] AXIS_KEEP_ALL = 4'hF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

endpackage

// File: rtl/adc_stream_packetizer_if.sv
// AXI-Stream master/slave bundle carrying packed ADC words towards the S2MM DMA.
interface adc_stream_packetizer_if
   import digitizer_pkg::*;
#(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, tkeep, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/adc_stream_packetizer_stream_fifo.sv
// Synchronous FWFT FIFO with a registered output stage and a tlast side bit.
// Occupancy (storage + output register) is capped at 2**AW words.
module stream_fifo #(
   parameter int DW = 32,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          i_wr_en,
   input  logic [DW-1:0] i_wr_data,
   input  logic          i_wr_last,
   input  logic          i_retag,
   output logic          o_full,
   output logic [DW-1:0] o_data,
   output logic          o_last,
   output logic          o_valid,
   input  logic          i_ready
);
   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

   logic [DW-1:0]    r_mem [DEPTH];
   logic [DEPTH-1:0] r_mem_last;
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [AW:0]      r_mem_cnt;
   logic [DW-1:0]    r_out_data;
   logic             r_out_last, r_out_vld;

   logic [AW-1:0] w_prev_ptr;
   logic [AW:0]   w_occ;
   logic          w_pop;

   assign w_prev_ptr = r_wr_ptr - AW'(1);
   assign w_occ      = r_mem_cnt + (AW + 1)'(r_out_vld);
   assign o_full     = (w_occ == FULL_OCC);
   assign w_pop      = (r_mem_cnt != '0) && (!r_out_vld || i_ready);

   // NOTE: the storage array is deliberately not reset; pointers and counts define validity.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[r_wr_ptr]      <= i_wr_data;
         r_mem_last[r_wr_ptr] <= i_wr_last;
      end
      if (i_retag) r_mem_last[w_prev_ptr] <= 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_mem_cnt  <= '0;
         r_out_data <= '0;
         r_out_last <= 1'b0;
         r_out_vld  <= 1'b0;
      end else begin
         if (i_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
         r_mem_cnt <= r_mem_cnt + (AW + 1)'(i_wr_en) - (AW + 1)'(w_pop);
         if (w_pop) begin
            // A retag landing on the entry being popped must reach the output register too.
            r_out_data <= r_mem[r_rd_ptr];
            r_out_last <= r_mem_last[r_rd_ptr] | (i_retag && (r_rd_ptr == w_prev_ptr));
            r_out_vld  <= 1'b1;
         end else if (r_out_vld && i_ready) begin
            r_out_vld  <= 1'b0;
         end
      end
   end

   assign o_data  = r_out_data;
   assign o_last  = r_out_last;
   assign o_valid = r_out_vld;
endmodule

// File: rtl/adc_stream_packetizer.sv
// Packs pairs of ADC samples into 32-bit AXIS words and emits one packet per start,
// with FIFO buffering, overflow accounting and tlast on the last word actually emitted.
module adc_stream_packetizer
   import digitizer_pkg::*;
#(
   parameter int SAMPLE_W = SAMPLE_W_DEF,
   parameter int FIFO_AW  = 4,
   parameter int SIZE_W   = 32,
   parameter int OVF_W    = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [SIZE_W-1:0]     packet_size,
   input  logic                  s_valid,
   input  logic [SAMPLE_W-1:0]   s_data,
   adc_stream_packetizer_if.master m_axis,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [OVF_W-1:0]      ovf_cnt
);
   localparam int CW     = SIZE_W - 2;
   localparam int WORD_W = 2 * SAMPLE_W;

   state_t              r_state;
   logic [CW-1:0]       r_nwords, r_wr_cnt, r_rd_cnt;
   logic                r_phase;
   logic [SAMPLE_W-1:0] r_lo;
   logic [WORD_W-1:0]   r_word;
   logic                r_word_vld;
   logic                r_busy, r_done, r_overflow;
   logic [OVF_W-1:0]    r_ovf_cnt;

   logic [CW-1:0]     w_size_words, w_rd_next;
   logic              w_start_ok, w_full, w_is_last, w_drop, w_wr_en, w_retag, w_hs;
   logic [WORD_W-1:0] w_out_data;
   logic              w_out_last, w_out_vld;
   logic              w_unused;

   assign w_unused     = ^packet_size[1:0];
   assign w_size_words = packet_size[SIZE_W-1:2];
   assign w_start_ok   = start && (r_state == IDLE) && (w_size_words != '0);
   assign w_is_last    = (r_wr_cnt == r_nwords - CW'(1));
   assign w_drop       = r_word_vld && w_full;
   assign w_wr_en      = r_word_vld && !w_full;
   assign w_retag      = w_drop && w_is_last;
   assign w_hs         = w_out_vld && m_axis.tready;
   // Drops advance the read count too, so it reaches nwords on the last emitted word.
   assign w_rd_next    = r_rd_cnt + CW'(w_hs) + CW'(w_drop);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_nwords   <= '0;
         r_wr_cnt   <= '0;
         r_rd_cnt   <= '0;
         r_phase    <= 1'b0;
         r_lo       <= '0;
         r_word     <= '0;
         r_word_vld <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
         r_ovf_cnt  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_ok) begin
                  r_nwords   <= w_size_words;
                  r_wr_cnt   <= '0;
                  r_rd_cnt   <= '0;
                  r_phase    <= 1'b0;
                  r_word_vld <= 1'b0;
                  r_overflow <= 1'b0;
                  r_ovf_cnt  <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= CAPTURE;
               end
            end
            CAPTURE: begin
               if (s_valid) begin
                  if (r_phase) r_word <= {s_data, r_lo};
                  else         r_lo   <= s_data;
                  r_phase <= ~r_phase;
               end
               r_word_vld <= s_valid && r_phase;
               r_rd_cnt   <= w_rd_next;
               if (r_word_vld) r_wr_cnt <= r_wr_cnt + CW'(1);
               if (w_drop) begin
                  r_overflow <= 1'b1;
                  if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
               end
               if (r_word_vld && w_is_last) r_state <= DRAIN;
            end
            DRAIN: begin
               r_word_vld <= 1'b0;
               r_rd_cnt   <= w_rd_next;
               if (w_rd_next == r_nwords) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   stream_fifo #(
      .DW (WORD_W),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .i_wr_en   (w_wr_en),
      .i_wr_data (r_word),
      .i_wr_last (w_is_last),
      .i_retag   (w_retag),
      .o_full    (w_full),
      .o_data    (w_out_data),
      .o_last    (w_out_last),
      .o_valid   (w_out_vld),
      .i_ready   (m_axis.tready)
   );

   assign m_axis.tdata  = w_out_data;
   assign m_axis.tlast  = w_out_last;
   assign m_axis.tvalid = w_out_vld;
   assign m_axis.tkeep  = AXIS_KEEP_ALL;

   assign busy     = r_busy;
   assign done     = r_done;
   assign overflow = r_overflow;
   assign ovf_cnt  = r_ovf_cnt;
endmodule

// File: tb/tb_adc_stream_packetizer.sv
// Directed bench for adc_stream_packetizer: packing, backpressure, overflow/retag,
// size corner cases, ignored starts and asynchronous reset mid-packet.
module tb_adc_stream_packetizer;
   localparam int SAMPLE_W = 16;
   localparam int FIFO_AW  = 4;
   localparam int SIZE_W   = 32;
   localparam int OVF_W    = 16;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              start = 1'b0;
   logic [SIZE_W-1:0] packet_size = '0;
   logic              s_valid = 1'b0;
   logic [15:0]       s_data = '0;
   logic              busy, done, overflow;
   logic [OVF_W-1:0]  ovf_cnt;

   adc_stream_packetizer_if #(.DATA_W(32)) axis ();

   adc_stream_packetizer #(
      .SAMPLE_W (SAMPLE_W),
      .FIFO_AW  (FIFO_AW),
      .SIZE_W   (SIZE_W),
      .OVF_W    (OVF_W)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .packet_size (packet_size),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .m_axis      (axis),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .ovf_cnt     (ovf_cnt)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_fail = 0;
   bit   rand_ready = 1'b0;

   // Monitor: records handshakes and done pulses, and counts stall-stability violations.
   logic [31:0] q_data[$];
   bit          q_last[$];
   int          done_cnt = 0;
   int          stall_viol = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_d = '0;
   logic        prev_l = 1'b0;

   always @(negedge clk) begin
      if (!resetn) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && !(axis.tvalid && axis.tdata == prev_d && axis.tlast == prev_l))
            stall_viol <= stall_viol + 1;
         if (axis.tvalid && axis.tready) begin
            q_data.push_back(axis.tdata);
            q_last.push_back(axis.tlast);
         end
         if (done) done_cnt <= done_cnt + 1;
         prev_stall <= axis.tvalid && !axis.tready;
         prev_d     <= axis.tdata;
         prev_l     <= axis.tlast;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) axis.tready = 1'($urandom_range(0, 1));
   endtask

   task automatic do_start(input int size);
      start       = 1'b1;
      packet_size = SIZE_W'(size);
      tick();
      start       = 1'b0;
   endtask

   task automatic send(input logic [15:0] d);
      s_valid = 1'b1;
      s_data  = d;
      tick();
      s_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, 64'(busy), 64'd0);
      tick();
      tick();
   endtask

   // Word j of a run of consecutive samples starting at sbase: {sample 2j+1, sample 2j}.
   task automatic check_pkt(input string tag, input int base, input int n, input logic [15:0] sbase);
      logic [15:0] lo, hi;
      check({tag, "_nwords"}, 64'(q_data.size() - base), 64'(n));
      for (int j = 0; j < n; j++) begin
         if (base + j < q_data.size()) begin
            lo = sbase + 16'(2 * j);
            hi = sbase + 16'(2 * j + 1);
            check($sformatf("%s_data%0d", tag, j), 64'(q_data[base + j]), 64'({hi, lo}));
            check($sformatf("%s_last%0d", tag, j), 64'(q_last[base + j]), 64'(j == n - 1));
         end
      end
   endtask

   initial begin
      int base, dbase;
      axis.tready = 1'b1;

      // Reset values
      #12;
      check("rst_tvalid", 64'(axis.tvalid), 64'd0);
      check("rst_tdata", 64'(axis.tdata), 64'd0);
      check("rst_tlast", 64'(axis.tlast), 64'd0);
      check("rst_tkeep", 64'(axis.tkeep), 64'hF);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_ovf", 64'({overflow, ovf_cnt}), 64'd0);
      @(posedge clk);
      #3 resetn = 1'b1;
      tick();

      // 1: alternating samples, size 16, tready high, first-word latency
      base = q_data.size(); dbase = done_cnt;
      do_start(16);
      check("t1_busy", 64'(busy), 64'd1);
      s_valid = 1'b1; s_data = 16'h00FF; tick();
      s_data = 16'hFF00; tick();
      s_valid = 1'b0;
      check("t1_lat_k0", 64'(axis.tvalid), 64'd0);
      tick();
      check("t1_lat_k1", 64'(axis.tvalid), 64'd0);
      tick();
      check("t1_lat_k2", 64'(axis.tvalid), 64'd1);
      for (int i = 0; i < 6; i++) send((i % 2 == 0) ? 16'h00FF : 16'hFF00);
      wait_idle("t1", 50);
      check("t1_nwords", 64'(q_data.size() - base), 64'd4);
      for (int j = 0; j < 4; j++) begin
         if (base + j < q_data.size()) begin
            check($sformatf("t1_data%0d", j), 64'(q_data[base + j]), 64'hFF0000FF);
            check($sformatf("t1_last%0d", j), 64'(q_last[base + j]), 64'(j == 3));
         end
      end
      check("t1_done_cnt", 64'(done_cnt - dbase), 64'd1);
      check("t1_done_low", 64'(done), 64'd0);

      // 2: size 64 with random backpressure
      base = q_data.size(); dbase = done_cnt;
      rand_ready = 1'b1;
      do_start(64);
      for (int i = 0; i < 32; i++) send(16'h1000 + 16'(i));
      wait_idle("t2", 400);
      rand_ready = 1'b0;
      axis.tready = 1'b1;
      tick();
      check_pkt("t2", base, 16, 16'h1000);
      check("t2_overflow", 64'(overflow), 64'd0);
      check("t2_stall_stable", 64'(stall_viol), 64'd0);
      check("t2_done_cnt", 64'(done_cnt - dbase), 64'd1);

      // 3: size 128 against a stalled sink: 16 stored, 16 dropped, last stored word retagged
      base = q_data.size(); dbase = done_cnt;
      axis.tready = 1'b0;
      do_start(128);
      for (int i = 0; i < 80; i++) send(16'h3000 + 16'(i));
      check("t3_overflow", 64'(overflow), 64'd1);
      check("t3_ovf_cnt", 64'(ovf_cnt), 64'd16);
      axis.tready = 1'b1;
      wait_idle("t3", 100);
      check_pkt("t3", base, 16, 16'h3000);
      check("t3_done_cnt", 64'(done_cnt - dbase), 64'd1);

      // 4: zero-word sizes ignored (overflow untouched), size 6 gives one word
      do_start(0);
      tick();
      check("t4_size0_busy", 64'(busy), 64'd0);
      do_start(3);
      tick();
      check("t4_size3_busy", 64'(busy), 64'd0);
      check("t4_ovf_kept", 64'(overflow), 64'd1);
      base = q_data.size();
      do_start(6);
      check("t4_ovf_clr", 64'({overflow, ovf_cnt}), 64'd0);
      send(16'hAAAA);
      send(16'hAAAB);
      wait_idle("t4", 50);
      check_pkt("t4", base, 1, 16'hAAAA);

      // 5: sample in the start cycle excluded; second start mid-capture ignored
      base = q_data.size(); dbase = done_cnt;
      start = 1'b1; packet_size = 32'd16; s_valid = 1'b1; s_data = 16'hDEAD;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1;
         s_data  = 16'h5000 + 16'(i);
         if (i == 3) begin
            start = 1'b1;
            packet_size = 32'd64;
         end
         tick();
         start = 1'b0;
      end
      s_valid = 1'b0;
      wait_idle("t5", 50);
      check_pkt("t5", base, 4, 16'h5000);
      check("t5_done_cnt", 64'(done_cnt - dbase), 64'd1);

      // 6: asynchronous reset mid-drain, then a clean 2-word packet
      axis.tready = 1'b0;
      do_start(64);
      for (int i = 0; i < 32; i++) send(16'h6000 + 16'(i));
      tick(); tick(); tick();
      check("t6_pre_busy", 64'(busy), 64'd1);
      check("t6_pre_tvalid", 64'(axis.tvalid), 64'd1);
      #2 resetn = 1'b0;
      #1;
      check("t6_rst_tvalid", 64'(axis.tvalid), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #3 resetn = 1'b1;
      axis.tready = 1'b1;
      tick();
      base = q_data.size();
      do_start(8);
      for (int i = 0; i < 4; i++) send(16'h7000 + 16'(i));
      wait_idle("t6", 50);
      check_pkt("t6", base, 2, 16'h7000);
      check("all_stall_stable", 64'(stall_viol), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
